// File: rtl/mem_copy_engine.sv
// Block-copy initiator on the data_memory A/WD/WE/RD port: read a word, write it, repeat.
// Optional COPY_CHECKSUM_EN adds a running modulo-2^32 sum of the words read.
module mem_copy_engine #(
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned AW    = 32,
    localparam int unsigned DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    src_base,
    input  logic [AW-1:0]    dst_base,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_A,
    output logic [DW-1:0]    mem_WD,
    output logic             mem_WE,
    input  logic [DW-1:0]    mem_RD
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0]    checksum
`endif
);

    localparam logic [AW-1:0] STEP = AW'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [AW-1:0]      src_q;
    logic [AW-1:0]      dst_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DW-1:0]      buf_q;
    logic               busy_q;
    logic               done_q;
    logic               we_q;
    logic [AW-1:0]      addr_q;
`ifdef COPY_CHECKSUM_EN
    logic [DW-1:0]      sum_q;
`endif

    // Outputs are loaded with the values belonging to the state being entered,
    // so each one is valid for the whole cycle of that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
`ifdef COPY_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
`ifdef COPY_CHECKSUM_EN
                        sum_q <= '0;
`endif
                        if (count != '0) begin
                            state_q <= S_READ;
                            src_q   <= src_base;
                            dst_q   <= dst_base;
                            cnt_q   <= count;
                            busy_q  <= 1'b1;
                            addr_q  <= src_base;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_WRITE;
                    buf_q   <= mem_RD;
                    src_q   <= src_q + STEP;
                    addr_q  <= dst_q;
                    we_q    <= 1'b1;
`ifdef COPY_CHECKSUM_EN
                    sum_q   <= sum_q + mem_RD;
`endif
                end
                S_WRITE: begin
                    dst_q <= dst_q + STEP;
                    cnt_q <= cnt_q - CNT_W'(1);
                    we_q  <= 1'b0;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        addr_q  <= '0;
                    end else begin
                        state_q <= S_READ;
                        addr_q  <= src_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    we_q    <= 1'b0;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign mem_A  = addr_q;
    assign mem_WD = buf_q;
    assign mem_WE = we_q;
`ifdef COPY_CHECKSUM_EN
    assign checksum = sum_q;
`endif

    // Structural invariants of the output encoding.
    a_we_busy : assert property (@(posedge clk) disable iff (!rst) mem_WE |-> busy);
    a_done_idle : assert property (@(posedge clk) disable iff (!rst) done |-> !busy);

endmodule
